// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and memory-side signals of the instruction
// memory port arbiter. The slave modport is the arbiter view; the master
// modport is the requester/memory environment view.
interface imem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  // Fetch path (read only)
  logic                  fe_req;
  logic [ADDR_WIDTH-1:0] fe_addr;
  logic                  fe_gnt;
  logic [DATA_WIDTH-1:0] fe_rdata;
  logic                  fe_rvalid;
  // Loader / debug path
  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_gnt;
  logic [DATA_WIDTH-1:0] ld_rdata;
  logic                  ld_rvalid;
  logic                  ld_start;
  logic                  ld_done;
  logic                  run;
  // Memory macro side
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  fe_req, fe_addr,
    output fe_gnt, fe_rdata, fe_rvalid,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_start, ld_done,
    output ld_gnt, ld_rdata, ld_rvalid, run,
    output mem_rd, mem_wr, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output fe_req, fe_addr,
    input  fe_gnt, fe_rdata, fe_rvalid,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_start, ld_done,
    input  ld_gnt, ld_rdata, ld_rvalid, run,
    input  mem_rd, mem_wr, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between the fetch path and the
// program loader. LOAD: loader only. RUN: loader has priority, but fetch is
// forced to win after MAX_WAIT consecutive losses. One access per cycle,
// read data returned with latency 1 to the registered owner.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       run_q;
  logic       fe_rv_q, fe_rv_d;
  logic       ld_rv_q, ld_rv_d;
  logic       fe_gnt, ld_gnt;

  // Per-cycle grant decision from requests, state and registered wait count
  always_comb begin
    fe_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (state_q == S_LOAD) begin
      ld_gnt = bus.ld_req;
    end else if (bus.fe_req && (!bus.ld_req || wait_q == WAIT_MAX)) begin
      fe_gnt = 1'b1;
    end else if (bus.ld_req) begin
      ld_gnt = 1'b1;
    end
  end

  // Drive the memory macro from whichever requester holds the grant
  always_comb begin
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    if (fe_gnt) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = bus.fe_addr;
    end else if (ld_gnt) begin
      bus.mem_addr = bus.ld_addr;
      if (bus.ld_we) begin
        bus.mem_wr      = 1'b1;
        bus.mem_wr_data = bus.ld_wdata;
      end else begin
        bus.mem_rd = 1'b1;
      end
    end
  end

  // Next-state: mode transitions, starvation counter and read-owner tags
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      S_LOAD: if (bus.ld_done) state_d = S_RUN;
      S_RUN: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
        end else if (bus.fe_req && !fe_gnt) begin
          // At WAIT_MAX a pending fetch always wins, so this cannot overflow
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = S_LOAD;
    endcase
    fe_rv_d = fe_gnt;
    ld_rv_d = ld_gnt && !bus.ld_we;
  end

  // State and registered outputs; reset discards any in-flight read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      wait_q  <= '0;
      run_q   <= 1'b0;
      fe_rv_q <= 1'b0;
      ld_rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= (state_d == S_RUN);
      fe_rv_q <= fe_rv_d;
      ld_rv_q <= ld_rv_d;
    end
  end

  // Output assignment; read data steered to the owner tagged at grant time
  always_comb begin
    bus.fe_gnt    = fe_gnt;
    bus.ld_gnt    = ld_gnt;
    bus.run       = run_q;
    bus.fe_rvalid = fe_rv_q;
    bus.ld_rvalid = ld_rv_q;
    bus.fe_rdata  = fe_rv_q ? bus.mem_rd_data : '0;
    bus.ld_rdata  = ld_rv_q ? bus.mem_rd_data : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus a
// randomised run against an arbitration model and a read-return scoreboard.
module tb_imem_port_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  typedef struct packed {
    logic          fe;
    logic [DW-1:0] data;
  } rd_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  rd_t           sbq[$];

  imem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: write on posedge, read data valid the next cycle
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rd) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fe_req   = 1'b0;
    bus.fe_addr  = '0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
    bus.ld_start = 1'b0;
    bus.ld_done  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (bus.run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %0b want 0", bus.run); end
    n_checks++; if (bus.fe_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_fe_rvalid got %0b want 0", bus.fe_rvalid); end
    n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ld_rvalid got %0b want 0", bus.ld_rvalid); end
    n_checks++; if (dut.wait_q !== 8'd0) begin n_fail++; $display("FAIL reset_wait got %0d want 0", dut.wait_q); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_write();
    next_cycle();
    idle();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 11'd5; bus.ld_wdata = 32'hDEADBEEF;
    bus.fe_req = 1'b1; bus.fe_addr = 11'd7;
    #1;
    n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL load_wr_strobe got wr=%0b rd=%0b want wr=1 rd=0", bus.mem_wr, bus.mem_rd); end
    n_checks++; if (bus.mem_addr !== 11'd5) begin n_fail++; $display("FAIL load_wr_addr got %0d want 5", bus.mem_addr); end
    n_checks++; if (bus.mem_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wr_data got %h want deadbeef", bus.mem_wr_data); end
    n_checks++; if (bus.fe_gnt !== 1'b0 || bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL load_gnt got fe=%0b ld=%0b want fe=0 ld=1", bus.fe_gnt, bus.ld_gnt); end
    n_checks++; if (bus.run !== 1'b0) begin n_fail++; $display("FAIL load_run got %0b want 0", bus.run); end
    shadow[5] = 32'hDEADBEEF;
  endtask

  task automatic test_done_fetch();
    next_cycle();
    idle();
    bus.ld_done = 1'b1;
    #1;
    next_cycle();
    idle();
    bus.fe_req = 1'b1; bus.fe_addr = 11'd5;
    #1;
    n_checks++; if (bus.run !== 1'b1) begin n_fail++; $display("FAIL done_run got %0b want 1", bus.run); end
    n_checks++; if (bus.fe_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL run_fe_gnt got fe=%0b ld=%0b want fe=1 ld=0", bus.fe_gnt, bus.ld_gnt); end
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 11'd5) begin n_fail++; $display("FAIL run_fe_mem got rd=%0b addr=%0d want rd=1 addr=5", bus.mem_rd, bus.mem_addr); end
    next_cycle();
    idle();
    #1;
    n_checks++; if (bus.fe_rvalid !== 1'b1 || bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL fe_return_valid got fe=%0b ld=%0b want fe=1 ld=0", bus.fe_rvalid, bus.ld_rvalid); end
    n_checks++; if (bus.fe_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fe_return_data got %h want deadbeef", bus.fe_rdata); end
    n_checks++; if (bus.ld_rdata !== 32'h0) begin n_fail++; $display("FAIL fe_return_ld_rdata got %h want 0", bus.ld_rdata); end
  endtask

  task automatic test_starvation();
    logic prev_fe;
    logic exp_fe;
    prev_fe = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      idle();
      bus.fe_req = 1'b1; bus.fe_addr = 11'(k);
      bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 11'd5;
      #1;
      exp_fe = ((k % 5) == 4);
      n_checks++; if (bus.fe_gnt !== exp_fe || bus.ld_gnt !== !exp_fe) begin n_fail++; $display("FAIL starve_gnt[%0d] got fe=%0b ld=%0b want fe=%0b ld=%0b", k, bus.fe_gnt, bus.ld_gnt, exp_fe, !exp_fe); end
      if (k > 0) begin
        n_checks++; if (bus.fe_rvalid !== prev_fe || bus.ld_rvalid !== !prev_fe) begin n_fail++; $display("FAIL starve_rvalid[%0d] got fe=%0b ld=%0b want fe=%0b ld=%0b", k, bus.fe_rvalid, bus.ld_rvalid, prev_fe, !prev_fe); end
      end
      if (k == 5) begin
        n_checks++; if (dut.wait_q !== 8'd0) begin n_fail++; $display("FAIL starve_wait_clear got %0d want 0", dut.wait_q); end
      end
      prev_fe = exp_fe;
    end
    next_cycle();
    idle();
    #1;
  endtask

  task automatic test_ld_read_start();
    next_cycle();
    idle();
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 11'd5; bus.ld_start = 1'b1;
    #1;
    n_checks++; if (bus.ld_gnt !== 1'b1 || bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL start_ld_gnt got gnt=%0b rd=%0b want 1 1", bus.ld_gnt, bus.mem_rd); end
    next_cycle();
    idle();
    bus.fe_req = 1'b1; bus.fe_addr = 11'd3;
    #1;
    n_checks++; if (bus.run !== 1'b0) begin n_fail++; $display("FAIL start_run got %0b want 0", bus.run); end
    n_checks++; if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL start_ld_return got v=%0b d=%h want v=1 d=deadbeef", bus.ld_rvalid, bus.ld_rdata); end
    n_checks++; if (bus.fe_gnt !== 1'b0 || bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL start_fe_blocked got gnt=%0b rd=%0b want 0 0", bus.fe_gnt, bus.mem_rd); end
    next_cycle();
    #1;
    n_checks++; if (bus.fe_gnt !== 1'b0 || bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_fe_blocked got gnt=%0b ldv=%0b want 0 0", bus.fe_gnt, bus.ld_rvalid); end
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    idle();
    bus.ld_done = 1'b1;
    #1;
    next_cycle();
    idle();
    bus.fe_req = 1'b1; bus.fe_addr = 11'd5;
    #1;
    n_checks++; if (bus.fe_gnt !== 1'b1) begin n_fail++; $display("FAIL inflight_fe_gnt got %0b want 1", bus.fe_gnt); end
    next_cycle();
    rst_n = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 11'd5;
    #1;
    n_checks++; if (bus.fe_rvalid !== 1'b1) begin n_fail++; $display("FAIL inflight_pre_rvalid got %0b want 1", bus.fe_rvalid); end
    next_cycle();
    rst_n = 1'b1;
    idle();
    #1;
    n_checks++; if (bus.fe_rvalid !== 1'b0 || bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL inflight_discard got fe=%0b ld=%0b want 0 0", bus.fe_rvalid, bus.ld_rvalid); end
    n_checks++; if (bus.run !== 1'b0) begin n_fail++; $display("FAIL inflight_run got %0b want 0", bus.run); end
    n_checks++; if (dut.wait_q !== 8'd0) begin n_fail++; $display("FAIL inflight_wait got %0d want 0", dut.wait_q); end
  endtask

  task automatic test_random();
    logic          m_run;
    int            m_wait;
    logic          e_fe, e_ld, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    rd_t           ent;
    logic          have;
    next_cycle();
    idle();
    rst_n = 1'b0;
    #1;
    m_run  = 1'b0;
    m_wait = 0;
    sbq.delete();
    for (int n = 0; n < 10000; n++) begin
      next_cycle();
      rst_n        = ($urandom_range(0, 499) != 0);
      bus.fe_req   = $urandom_range(0, 3) != 0;
      bus.fe_addr  = 11'($urandom_range(0, 15));
      bus.ld_req   = $urandom_range(0, 2) != 0;
      bus.ld_we    = $urandom_range(0, 1) != 0;
      bus.ld_addr  = 11'($urandom_range(0, 15));
      bus.ld_wdata = $urandom;
      bus.ld_start = ($urandom_range(0, 49) == 0);
      bus.ld_done  = ($urandom_range(0, 19) == 0);
      #1;
      e_fe = 1'b0; e_ld = 1'b0;
      if (!m_run) e_ld = bus.ld_req;
      else if (bus.fe_req && (!bus.ld_req || m_wait == int'(MW))) e_fe = 1'b1;
      else if (bus.ld_req) e_ld = 1'b1;
      e_rd = e_fe || (e_ld && !bus.ld_we);
      e_wr = e_ld && bus.ld_we;
      e_addr  = e_fe ? bus.fe_addr : (e_ld ? bus.ld_addr : '0);
      e_wdata = e_wr ? bus.ld_wdata : '0;
      n_checks++; if (bus.run !== m_run) begin n_fail++; $display("FAIL rnd_run[%0d] got %0b want %0b", n, bus.run, m_run); end
      n_checks++; if (bus.fe_gnt !== e_fe) begin n_fail++; $display("FAIL rnd_fe_gnt[%0d] got %0b want %0b", n, bus.fe_gnt, e_fe); end
      n_checks++; if (bus.ld_gnt !== e_ld) begin n_fail++; $display("FAIL rnd_ld_gnt[%0d] got %0b want %0b", n, bus.ld_gnt, e_ld); end
      n_checks++; if ((bus.fe_gnt & bus.ld_gnt) !== 1'b0) begin n_fail++; $display("FAIL rnd_dual_gnt[%0d] got 1 want 0", n); end
      n_checks++; if (bus.mem_rd !== e_rd || bus.mem_wr !== e_wr) begin n_fail++; $display("FAIL rnd_strobe[%0d] got rd=%0b wr=%0b want rd=%0b wr=%0b", n, bus.mem_rd, bus.mem_wr, e_rd, e_wr); end
      n_checks++; if (bus.mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %0d want %0d", n, bus.mem_addr, e_addr); end
      n_checks++; if (bus.mem_wr_data !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d] got %h want %h", n, bus.mem_wr_data, e_wdata); end
      n_checks++; if (dut.wait_q !== 8'(m_wait)) begin n_fail++; $display("FAIL rnd_wait[%0d] got %0d want %0d", n, dut.wait_q, m_wait); end
      have = (sbq.size() > 0);
      ent  = '0;
      if (have) ent = sbq.pop_front();
      n_checks++; if (bus.fe_rvalid !== (have && ent.fe) || bus.ld_rvalid !== (have && !ent.fe)) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got fe=%0b ld=%0b want fe=%0b ld=%0b", n, bus.fe_rvalid, bus.ld_rvalid, have && ent.fe, have && !ent.fe); end
      n_checks++; if (bus.fe_rdata !== ((have && ent.fe) ? ent.data : '0)) begin n_fail++; $display("FAIL rnd_fe_rdata[%0d] got %h want %h", n, bus.fe_rdata, (have && ent.fe) ? ent.data : '0); end
      n_checks++; if (bus.ld_rdata !== ((have && !ent.fe) ? ent.data : '0)) begin n_fail++; $display("FAIL rnd_ld_rdata[%0d] got %h want %h", n, bus.ld_rdata, (have && !ent.fe) ? ent.data : '0); end
      if (e_rd) sbq.push_back('{fe: e_fe, data: shadow[e_addr]});
      if (e_wr) shadow[bus.ld_addr] = bus.ld_wdata;
      if (!rst_n) begin
        m_run = 1'b0; m_wait = 0; sbq.delete();
      end else if (!m_run) begin
        m_wait = 0;
        if (bus.ld_done) m_run = 1'b1;
      end else if (bus.ld_start) begin
        m_run = 1'b0; m_wait = 0;
      end else if (bus.fe_req && !e_fe) begin
        m_wait = m_wait + 1;
      end else begin
        m_wait = 0;
      end
    end
    next_cycle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.mem_rd_data = '0;
    idle();
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    test_reset();
    test_load_write();
    test_done_fetch();
    test_starvation();
    test_ld_read_start();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
